// File: rtl/bram_arb_pkg.sv
// ============================================================================
// Module  : bram_arb_pkg
// Purpose : Shared constants and types for the two-port BRAM arbiter.
// Rev     : 1.0
// ============================================================================
`default_nettype none

package bram_arb_pkg;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DBG = 1'b1;

    localparam int DEF_ADDR_W = 10;
    localparam int DEF_DATA_W = 16;
    localparam int DEF_RD_LAT = 1;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_DBG  = 2'd2
    } owner_t;

    typedef struct packed {
        logic valid;
        logic port;
    } rd_tag_t;

endpackage

`default_nettype wire

// File: rtl/bram_rd_tracker.sv
// ============================================================================
// Module  : bram_rd_tracker
// Purpose : RD_LAT-deep read tag delay line; steers rvalid to the issuing port.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module bram_rd_tracker
    import bram_arb_pkg::*;
#(
    parameter int RD_LAT = DEF_RD_LAT
) (
    input  logic    clk,
    input  logic    RESET,
    input  rd_tag_t tag_in,
    output logic    rvalid0,
    output logic    rvalid1
);

    rd_tag_t r_pipe [RD_LAT];

    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < RD_LAT; i++) begin
                r_pipe[i] <= '0;
            end
        end else begin
            r_pipe[0] <= tag_in;
            for (int i = 1; i < RD_LAT; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    assign rvalid0 = r_pipe[RD_LAT-1].valid && (r_pipe[RD_LAT-1].port == PORT_CPU);
    assign rvalid1 = r_pipe[RD_LAT-1].valid && (r_pipe[RD_LAT-1].port == PORT_DBG);

endmodule

`default_nettype wire

// File: rtl/bram_port_arbiter.sv
// ============================================================================
// Module  : bram_port_arbiter
// Purpose : Shares one single-port BRAM between CPU (port 0) and debug (port 1)
//           with lock/burst support. Define BRAM_ARB_RR_EN for round-robin.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module bram_port_arbiter
    import bram_arb_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int RD_LAT    = DEF_RD_LAT,
    parameter int MAX_BURST = 8
) (
    input  logic              clk,
    input  logic              RESET,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic              lock0,
    input  logic              lock1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata,
    output logic              bram_ce,
    output logic              bram_wre,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [DATA_W-1:0] bram_di,
    input  logic [DATA_W-1:0] bram_do
);

    localparam logic [7:0] C_MAX_BURST = 8'(MAX_BURST);

    owner_t     r_owner;
    logic [7:0] r_burst_cnt;
    logic       r_burst_port;   // port that r_burst_cnt is counting for
    logic       w_cap;
    logic       w_pref;
    logic       w_win_valid;
    logic       w_win;
    logic       w_other_req;
    logic       w_win_lock;
    rd_tag_t    w_tag;

`ifdef BRAM_ARB_RR_EN
    logic r_last;
    assign w_pref = ~r_last;
`else
    assign w_pref = PORT_CPU;
`endif

    always_comb begin
        w_win_valid = 1'b0;
        w_win       = PORT_CPU;
        w_cap       = (r_burst_cnt == C_MAX_BURST);
        if (r_owner == OWN_CPU && req0) begin
            w_win_valid = 1'b1;
            w_win       = (w_cap && r_burst_port == PORT_CPU && req1) ? PORT_DBG : PORT_CPU;
        end else if (r_owner == OWN_DBG && req1) begin
            w_win_valid = 1'b1;
            w_win       = (w_cap && r_burst_port == PORT_DBG && req0) ? PORT_CPU : PORT_DBG;
        end else if (req0 && !req1) begin
            w_win_valid = 1'b1;
            w_win       = PORT_CPU;
        end else if (req1 && !req0) begin
            w_win_valid = 1'b1;
            w_win       = PORT_DBG;
        end else if (req0 && req1) begin
            w_win_valid = 1'b1;
            w_win       = w_cap ? ~r_burst_port : w_pref;
        end
    end

    // Grants are forced low while reset is held so the BRAM sees no access.
    assign gnt0        = w_win_valid && (w_win == PORT_CPU) && !RESET;
    assign gnt1        = w_win_valid && (w_win == PORT_DBG) && !RESET;
    assign bram_ce     = gnt0 || gnt1;
    assign bram_wre    = bram_ce && (gnt1 ? we1 : we0);
    assign bram_addr   = gnt1 ? addr1 : addr0;
    assign bram_di     = gnt1 ? wdata1 : wdata0;
    assign rdata       = bram_do;
    assign w_other_req = (w_win == PORT_DBG) ? req0 : req1;
    assign w_win_lock  = (w_win == PORT_DBG) ? lock1 : lock0;

    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            r_owner      <= OWN_NONE;
            r_burst_cnt  <= 8'd0;
            r_burst_port <= PORT_CPU;
        end else if (bram_ce) begin
            r_burst_port <= w_win;
            if (!w_other_req) begin
                r_burst_cnt <= 8'd0;
            end else if (w_win == r_burst_port && r_burst_cnt != 8'd0) begin
                r_burst_cnt <= w_cap ? r_burst_cnt : r_burst_cnt + 8'd1;
            end else begin
                r_burst_cnt <= 8'd1;
            end
            if (w_win_lock) begin
                r_owner <= (w_win == PORT_DBG) ? OWN_DBG : OWN_CPU;
            end else begin
                r_owner <= OWN_NONE;
            end
        end else begin
            r_burst_cnt <= 8'd0;
            r_owner     <= OWN_NONE;
        end
    end

`ifdef BRAM_ARB_RR_EN
    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            r_last <= PORT_DBG;
        end else if (bram_ce) begin
            r_last <= w_win;
        end
    end
`endif

    assign w_tag.valid = bram_ce && !bram_wre;
    assign w_tag.port  = gnt1;

    bram_rd_tracker #(
        .RD_LAT (RD_LAT)
    ) u_rd_tracker (
        .clk     (clk),
        .RESET   (RESET),
        .tag_in  (w_tag),
        .rvalid0 (rvalid0),
        .rvalid1 (rvalid1)
    );

endmodule

`default_nettype wire

// File: tb/tb_bram_port_arbiter.sv
// ============================================================================
// Module  : tb_bram_port_arbiter
// Purpose : Directed self-checking bench for bram_port_arbiter (RD_LAT = 1).
// Rev     : 1.0
// ============================================================================
`default_nettype none

module tb_bram_port_arbiter;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 16;

    logic              clk = 1'b0;
    logic              RESET = 1'b1;
    logic              req0 = 1'b0, req1 = 1'b0;
    logic              we0 = 1'b0, we1 = 1'b0;
    logic              lock0 = 1'b0, lock1 = 1'b0;
    logic [ADDR_W-1:0] addr0 = '0, addr1 = '0;
    logic [DATA_W-1:0] wdata0 = '0, wdata1 = '0;
    logic              gnt0, gnt1, rvalid0, rvalid1;
    logic [DATA_W-1:0] rdata;
    logic              bram_ce, bram_wre;
    logic [ADDR_W-1:0] bram_addr;
    logic [DATA_W-1:0] bram_di;
    logic [DATA_W-1:0] bram_do = '0;

    int n_tests = 0;
    int n_fail  = 0;
    int cnt0, cnt1;

    bram_port_arbiter #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .RD_LAT    (1),
        .MAX_BURST (4)
    ) dut (
        .clk       (clk),
        .RESET     (RESET),
        .req0      (req0),
        .req1      (req1),
        .we0       (we0),
        .we1       (we1),
        .lock0     (lock0),
        .lock1     (lock1),
        .addr0     (addr0),
        .addr1     (addr1),
        .wdata0    (wdata0),
        .wdata1    (wdata1),
        .gnt0      (gnt0),
        .gnt1      (gnt1),
        .rvalid0   (rvalid0),
        .rvalid1   (rvalid1),
        .rdata     (rdata),
        .bram_ce   (bram_ce),
        .bram_wre  (bram_wre),
        .bram_addr (bram_addr),
        .bram_di   (bram_di),
        .bram_do   (bram_do)
    );

    always #5 clk = ~clk;

    // Single-port BRAM model, one-cycle read latency, write-first.
    logic [DATA_W-1:0] mem [1024];
    logic              mem_init_done = 1'b0;
    always @(posedge clk) begin
        if (!mem_init_done) begin
            mem[0]        <= 16'hC845;
            mem[1]        <= 16'h1111;
            mem[2]        <= 16'h2222;
            mem[5]        <= 16'h0000;
            mem_init_done <= 1'b1;
        end else if (bram_ce) begin
            if (bram_wre) begin
                mem[bram_addr] <= bram_di;
                bram_do        <= bram_di;
            end else begin
                bram_do <= mem[bram_addr];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        req0 = 0; req1 = 0; we0 = 0; we1 = 0; lock0 = 0; lock1 = 0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    endtask

    task automatic do_reset;
        idle_inputs();
        RESET = 1;
        tick();
        tick();
        RESET = 0;
    endtask

    initial begin
        // Reset state, with requests held to confirm grants are suppressed.
        req0 = 1; req1 = 1;
        #3;
        check("rst_gnt0", gnt0, 0);
        check("rst_gnt1", gnt1, 0);
        check("rst_ce", bram_ce, 0);
        check("rst_wre", bram_wre, 0);
        check("rst_rvalid0", rvalid0, 0);
        check("rst_rvalid1", rvalid1, 0);
        do_reset();

        // 1: port 1 alone reads addr 0
        req1 = 1; addr1 = 10'd0;
        #4;
        check("t1_gnt1", gnt1, 1);
        check("t1_gnt0", gnt0, 0);
        check("t1_wre", bram_wre, 0);
        tick();
        req1 = 0;
        #4;
        check("t1_rvalid1", rvalid1, 1);
        check("t1_rdata", rdata, 16'hC845);
        check("t1_rvalid0", rvalid0, 0);
        tick();
        #4;
        check("t1_rvalid1_clr", rvalid1, 0);

        // 2: simultaneous reads, fixed order 0 then 1
        do_reset();
        req0 = 1; req1 = 1; addr0 = 10'd1; addr1 = 10'd2;
        #4;
        check("t2_c0_gnt0", gnt0, 1);
        check("t2_c0_gnt1", gnt1, 0);
        tick();
        req0 = 0;
        #4;
        check("t2_c1_gnt1", gnt1, 1);
        check("t2_c1_rvalid0", rvalid0, 1);
        check("t2_c1_rdata", rdata, 16'h1111);
        tick();
        req1 = 0;
        #4;
        check("t2_c2_rvalid1", rvalid1, 1);
        check("t2_c2_rvalid0", rvalid0, 0);
        check("t2_c2_rdata", rdata, 16'h2222);

        // 3: locked burst on port 0 bounded at 4 grants
        do_reset();
        req0 = 1; lock0 = 1; req1 = 1;
        for (int i = 0; i < 10; i++) begin
            #4;
            check($sformatf("t3_gnt1_c%0d", i), gnt1, (i == 4 || i == 9) ? 1 : 0);
            check($sformatf("t3_gnt0_c%0d", i), gnt0, (i == 4 || i == 9) ? 0 : 1);
            tick();
        end
        idle_inputs();

        // 4: write then read of the same address
        do_reset();
        req0 = 1; we0 = 1; addr0 = 10'd5; wdata0 = 16'hBEEF;
        #4;
        check("t4_gnt0", gnt0, 1);
        check("t4_wre", bram_wre, 1);
        check("t4_addr", bram_addr, 10'd5);
        check("t4_di", bram_di, 16'hBEEF);
        tick();
        req0 = 0; we0 = 0; req1 = 1; addr1 = 10'd5;
        #4;
        check("t4_gnt1", gnt1, 1);
        check("t4_rvalid0_w", rvalid0, 0);
        tick();
        req1 = 0;
        #4;
        check("t4_rvalid1", rvalid1, 1);
        check("t4_rvalid0", rvalid0, 0);
        check("t4_rdata", rdata, 16'hBEEF);

        // 5: reset right after a granted read kills its rvalid
        do_reset();
        req1 = 1; addr1 = 10'd0;
        #4;
        check("t5_gnt1", gnt1, 1);
        tick();
        req1 = 0; req0 = 1; RESET = 1;
        #4;
        check("t5_rvalid1_rst", rvalid1, 0);
        check("t5_gnt0_rst", gnt0, 0);
        check("t5_ce_rst", bram_ce, 0);
        tick();
        RESET = 0; req0 = 0;
        #4;
        check("t5_rvalid1_after", rvalid1, 0);
        check("t5_rvalid0_after", rvalid0, 0);

        // 6: continuous contention without lock
        do_reset();
        req0 = 1; req1 = 1;
        cnt0 = 0; cnt1 = 0;
        for (int i = 0; i < 10; i++) begin
            #4;
            if (gnt0) cnt0++;
            if (gnt1) cnt1++;
`ifdef BRAM_ARB_RR_EN
            check($sformatf("t6_gnt1_c%0d", i), gnt1, (i % 2 == 1) ? 1 : 0);
`else
            check($sformatf("t6_gnt1_c%0d", i), gnt1, (i == 4 || i == 9) ? 1 : 0);
`endif
            tick();
        end
        idle_inputs();
`ifdef BRAM_ARB_RR_EN
        check("t6_cnt0", cnt0, 5);
        check("t6_cnt1", cnt1, 5);
`else
        check("t6_cnt0", cnt0, 8);
        check("t6_cnt1", cnt1, 2);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
